// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction memory and
// feeds the IF/ID register, with a one-entry skid buffer for words returned during a stall.
module if_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_hold,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_data,
    output logic [ADDR_W-1:0] pc_plus4_IF,
    output logic [DATA_W-1:0] inst_IF
);

    typedef enum logic [1:0] {
        S_REQ      = 2'd0,
        S_HOLD_BUF = 2'd1,
        S_DRAIN    = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_req_addr;
    logic [DATA_W-1:0] r_buf;
    logic [ADDR_W-1:0] r_buf_pc4;
    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc4;

    state_t            w_next_state;
    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_req_addr;
    logic [DATA_W-1:0] w_buf;
    logic [ADDR_W-1:0] w_buf_pc4;
    logic [DATA_W-1:0] w_inst;
    logic [ADDR_W-1:0] w_pc4;
    logic              w_req;
    logic              w_redir;
    logic [ADDR_W-1:0] w_req_plus4;

    assign w_redir     = branch_taken & ~is_hold;
    assign w_req_plus4 = r_req_addr + ADDR_W'(4);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_buf      <= NOP_INST;
            r_buf_pc4  <= RESET_PC;
            r_inst     <= NOP_INST;
            r_pc4      <= RESET_PC;
        end else begin
            r_state    <= w_next_state;
            r_pc       <= w_pc;
            r_req_addr <= w_req_addr;
            r_buf      <= w_buf;
            r_buf_pc4  <= w_buf_pc4;
            r_inst     <= w_inst;
            r_pc4      <= w_pc4;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc         = r_pc;
        w_req_addr   = r_req_addr;
        w_buf        = r_buf;
        w_buf_pc4    = r_buf_pc4;
        w_inst       = r_inst;
        w_pc4        = r_pc4;
        w_req        = 1'b1;

        case (r_state)
            S_REQ: begin
                if (w_redir) begin
                    // A fetch still outstanding at redirect is wrong-path; DRAIN swallows it.
                    w_pc   = branch_target;
                    w_inst = NOP_INST;
                    if (imem_ready) begin
                        w_req_addr = branch_target;
                    end else begin
                        w_next_state = S_DRAIN;
                    end
                end else if (imem_ready) begin
                    w_pc       = w_req_plus4;
                    w_req_addr = w_req_plus4;
                    if (is_hold) begin
                        w_buf        = imem_data;
                        w_buf_pc4    = w_req_plus4;
                        w_next_state = S_HOLD_BUF;
                    end else begin
                        w_inst = imem_data;
                        w_pc4  = w_req_plus4;
                    end
                end else if (!is_hold) begin
                    w_inst = NOP_INST;
                    w_pc4  = r_req_addr;
                end
            end

            S_HOLD_BUF: begin
                w_req = 1'b0;
                if (w_redir) begin
                    w_pc         = branch_target;
                    w_req_addr   = branch_target;
                    w_inst       = NOP_INST;
                    w_next_state = S_REQ;
                end else if (!is_hold) begin
                    w_inst       = r_buf;
                    w_pc4        = r_buf_pc4;
                    w_next_state = S_REQ;
                end
            end

            S_DRAIN: begin
                if (w_redir) begin
                    w_pc = branch_target;
                end
                if (imem_ready) begin
                    w_req_addr   = w_redir ? branch_target : r_pc;
                    w_next_state = S_REQ;
                end
                if (!is_hold) begin
                    w_inst = NOP_INST;
                end
            end

            default: begin
                w_next_state = S_REQ;
            end
        endcase
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_req_addr;
    assign pc_plus4_IF = r_pc4;
    assign inst_IF     = r_inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a variable-latency memory, random stalls and
// redirects, and a program-order scoreboard of the words that must reach IF/ID.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] TAG      = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_hold = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic [31:0] pc_plus4_IF;
    logic [31:0] inst_IF;

    int compareCount  = 0;
    int mismatchCount = 0;
    int realCount     = 0;
    int waitMin       = 0;
    int waitMax       = 0;
    int waitCnt       = 0;
    int curWait       = 0;

    if_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .RESET_PC(RESET_PC),
        .NOP_INST(NOP_INST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .is_hold      (is_hold),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_data    (imem_data),
        .pc_plus4_IF  (pc_plus4_IF),
        .inst_IF      (inst_IF)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Memory answers each request after a random latency with mem[a] = a | A000_0000.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            imem_ready <= 1'b0;
            imem_data  <= '0;
            waitCnt    <= 0;
            curWait    <= waitMin;
        end else if (imem_req) begin
            if (waitCnt >= curWait) begin
                imem_ready <= 1'b1;
                imem_data  <= imem_addr | TAG;
                waitCnt    <= 0;
                curWait    <= int'($urandom_range(waitMax, waitMin));
            end else begin
                imem_ready <= 1'b0;
                waitCnt    <= waitCnt + 1;
            end
        end else begin
            imem_ready <= 1'b0;
            waitCnt    <= 0;
        end
    end

    // Reference model: the architectural instruction stream plus two facts about the fetch
    // pipe -- a word parked during a stall, and a wrong-path fetch still owed by memory.
    logic [31:0] expQ[$];
    logic [31:0] nextAddr;
    logic [31:0] prevInst;
    logic [31:0] prevPc4;
    logic        parked;
    logic        owed;

    function automatic void restartStream(input logic [31:0] start);
        expQ.delete();
        nextAddr = start;
    endfunction

    function automatic void refill();
        while (expQ.size() < 4) begin
            expQ.push_back(nextAddr);
            nextAddr = nextAddr + 32'd4;
        end
    endfunction

    initial begin
        logic        sRst, sHold, sRedir, sReq, sReady, expectReal;
        logic [31:0] sTarget, sAddr, expAddr;
        restartStream(RESET_PC);
        prevInst = NOP_INST;
        prevPc4  = RESET_PC;
        parked   = 1'b0;
        owed     = 1'b0;
        forever begin
            @(posedge clk);
            sRst    = rst;
            sHold   = is_hold;
            sRedir  = branch_taken & ~is_hold;
            sTarget = branch_target;
            sReq    = imem_req;
            sReady  = imem_ready;
            sAddr   = imem_addr;
            #1;
            if (!sRst || !rst) begin
                restartStream(RESET_PC);
                prevInst = NOP_INST;
                prevPc4  = RESET_PC;
                parked   = 1'b0;
                owed     = 1'b0;
            end else begin
                refill();
                expectReal = !sHold && !sRedir && (parked || (sReady && !owed));
                if (sHold) begin
                    checkOutput("hold_inst", inst_IF, prevInst);
                    checkOutput("hold_pc4", pc_plus4_IF, prevPc4);
                end else if (expectReal) begin
                    expAddr = expQ.pop_front();
                    checkOutput("word_inst", inst_IF, expAddr | TAG);
                    checkOutput("word_pc4", pc_plus4_IF, expAddr + 32'd4);
                    realCount++;
                end else begin
                    checkOutput("bubble", inst_IF, NOP_INST);
                end
                if (sReq && !sReady) begin
                    checkOutput("addr_stable", imem_addr, sAddr);
                end
                if (sRedir) begin
                    restartStream(sTarget);
                    if (sReq && !sReady && !parked) owed = 1'b1;
                    parked = 1'b0;
                end else if (parked && !sHold) begin
                    parked = 1'b0;
                end else if (!parked && !owed && sReady && sHold) begin
                    parked = 1'b1;
                end
                if (sReady) owed = 1'b0;
                checkOutput("req", {31'd0, imem_req}, {31'd0, !parked});
                prevInst = inst_IF;
                prevPc4  = pc_plus4_IF;
            end
        end
    end

    function automatic logic [31:0] pickTarget();
        case ($urandom_range(3, 0))
            0:       return 32'h0000_0100;
            1:       return 32'h0000_0200;
            2:       return 32'hFFFF_FFF8;
            default: return {20'd0, $urandom_range(1023, 0), 2'b00};
        endcase
    endfunction

    task automatic applyStimulus(input int cycles, input int holdPct, input int brPct);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            is_hold       = ($urandom_range(99, 0) < holdPct);
            branch_taken  = !is_hold && ($urandom_range(99, 0) < brPct);
            branch_target = pickTarget();
        end
        @(negedge clk);
        is_hold      = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_inst"}, inst_IF, NOP_INST);
        checkOutput({tag, "_pc4"}, pc_plus4_IF, RESET_PC);
        checkOutput({tag, "_addr"}, imem_addr, RESET_PC);
        checkOutput({tag, "_req"}, {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #1;
        checkResetState("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        $display("[TB] zero-wait streaming");
        applyStimulus(30, 0, 0);
        $display("[TB] two-wait memory");
        waitMin = 2; waitMax = 2;
        applyStimulus(40, 0, 0);
        $display("[TB] zero-wait with stalls and redirects");
        waitMin = 0; waitMax = 0;
        applyStimulus(400, 30, 10);
        $display("[TB] variable latency with stalls and redirects");
        waitMin = 0; waitMax = 3;
        applyStimulus(800, 25, 8);

        $display("[TB] reset in the middle of a memory wait");
        waitMin = 3; waitMax = 3;
        applyStimulus(6, 0, 0);
        for (int i = 0; i < 8 && !(imem_req && !imem_ready && imem_addr != RESET_PC); i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checkResetState("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        waitMin = 0; waitMax = 1;
        applyStimulus(100, 20, 5);

        checkOutput("progress", {31'd0, realCount >= 200}, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage. Owns the PC and runs a req/ready handshake with instruction memory.
- Presents pc_plus4_IF/inst_IF to the IF/ID pipeline register, which advances only on edges where is_hold=0.
- Handles stalls without losing a returned instruction, using a one-entry skid buffer.
- Handles taken-branch redirects, including discarding a wrong-path fetch still in flight (MIPS delay slot is preserved).

Parameters:
- ADDR_W, 32, instruction address width
- DATA_W, 32, instruction word width
- RESET_PC, 32'h0000_0000, first fetch address
- NOP_INST, 32'h0000_0000, bubble word (sll $0,$0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- is_hold  in  1  stall; same signal that freezes IF/ID
- branch_taken  in  1  redirect request from ID; single-cycle pulse
- branch_target  in  ADDR_W  redirect address, valid with branch_taken
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1 until imem_ready
- imem_ready  in  1  one-cycle pulse, data valid; may arrive in the same cycle as imem_req
- imem_data  in  DATA_W  instruction word
- pc_plus4_IF  out  ADDR_W  address of presented instruction + 4
- inst_IF  out  DATA_W  presented instruction, or NOP_INST bubble

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC, req_addr=RESET_PC, state=REQ
  - inst_IF=NOP_INST, pc_plus4_IF=RESET_PC, skid buffer empty
- Request outputs:
  - imem_req=1 in REQ and DRAIN; 0 in HOLD_BUF.
  - imem_addr=req_addr (registered).
- Effective redirect: redir = branch_taken & ~is_hold. branch_taken while is_hold=1 is ignored; the hazard unit never produces it.
- Output register update: pc_plus4_IF/inst_IF update only on edges with is_hold=0; otherwise they hold.

State REQ:
- imem_ready=1, no redir, is_hold=0:
  - inst_IF<=imem_data, pc_plus4_IF<=req_addr+4
  - pc<=req_addr+4, req_addr<=req_addr+4
  - Throughput is one instruction per cycle with zero-wait memory.
- imem_ready=1, is_hold=1:
  - buf<=imem_data, buf_pc4<=req_addr+4
  - pc and req_addr advance by 4; go to HOLD_BUF
- imem_ready=0, no redir, is_hold=0: inst_IF<=NOP_INST, pc_plus4_IF<=req_addr (bubble).
- imem_ready=0, is_hold=1: hold everything.
- redir with imem_ready=1:
  - discard the data; pc<=branch_target, req_addr<=branch_target
  - inst_IF<=NOP_INST; stay in REQ
- redir with imem_ready=0:
  - pc<=branch_target, inst_IF<=NOP_INST
  - req_addr unchanged; go to DRAIN

State HOLD_BUF:
- is_hold=1: hold all state.
- is_hold=0:
  - inst_IF<=buf, pc_plus4_IF<=buf_pc4; buffer empties; go to REQ
  - req_addr already points to the next fetch
- redir in HOLD_BUF: the buffered word is wrong-path. Drop it; pc<=branch_target, req_addr<=branch_target, inst_IF<=NOP_INST; go to REQ.

State DRAIN:
- imem_req stays high at the old req_addr.
- imem_ready=1: discard the data; req_addr<=pc; go to REQ.
- Outputs: NOP_INST on each edge with is_hold=0.
- A second redir in DRAIN overwrites pc only.

General rules:
- Delay slot: the instruction presented when redir occurs is captured by IF/ID on that edge. Only the fetch after it is squashed.
- Address arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0. Low two bits are passed through, not checked.
- Reset mid-transaction: all state is cleared immediately. Any later imem_ready for the old request is treated as the response to the new RESET_PC request; the memory model must also be reset.
- Illegal state encodings recover to REQ.

Test Plan:
- Zero-wait memory (imem_ready=1 every cycle, mem[a]=a|0xA000_0000), rst released → inst_IF = A000_0000, A000_0004, A000_0008 on consecutive edges; pc_plus4_IF = 4, 8, 12.
- Two-wait memory → each instruction is preceded by two NOP_INST bubbles; imem_addr stable during the wait; pc_plus4_IF of the real word = addr+4.
- is_hold=1 for 3 cycles, asserted in the same cycle imem_ready returns word at 0x10 → inst_IF frozen at the 0x0C word; imem_req=0 during the hold; the 0x10 word is presented on the first edge after is_hold falls; no word lost or duplicated.
- branch_taken with target 0x100 while fetch at 0x14 returns same cycle → the 0x10 word (delay slot) still presented; next output NOP; following word from 0x100, pc_plus4_IF=0x104.
- branch_taken to 0x200 during a 3-cycle memory wait at 0x20 → imem_addr stays 0x20 until ready; that data is dropped; next request is 0x200; no 0x20 word appears on inst_IF.
- rst asserted low mid-wait → outputs immediately NOP_INST/RESET_PC, imem_addr=RESET_PC; normal fetch resumes after release.
